// File: rtl/apple1_pkg.sv
// apple1_pkg: shared RAM geometry and arbitration types for the Apple-1 RAM path
package apple1_pkg;
    localparam int RAM_ADDR_W = 13;
    localparam int RAM_DATA_W = 8;
    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VID, OWN_LDR} owner;
    typedef enum logic {SEC_IDLE, SEC_WAIT} sec_state;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter that yields entirely while blocked
module rr_arbiter2 (
    input  logic       clk25,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       block,
    output logic [1:0] gnt
);
    logic rr_last;
    // grant the lone requester, or the one not served last when both ask
    always_comb gnt = (block || reset) ? 2'b00 : (&req) ? (rr_last ? 2'b01 : 2'b10) : req;
    // remember which requester won last; reset favours requester 0 first
    always_ff @(posedge clk25)
        if (reset) rr_last <= 1'b1;
        else if (|gnt) rr_last <= gnt[1];
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port main RAM between the CPU, video reads and loader writes
import apple1_pkg::*;
module ram_arbiter #(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              clk25,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_valid,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_dout,
    input  logic              ldr_req,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_din,
    output logic              ldr_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);
    sec_state          vid_st, vid_nx, ldr_st, ldr_nx;
    owner              inflight_owner, owner_nx;
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_din, cpu_hold, vid_hold;

    rr_arbiter2 u_rr (
        .clk25 (clk25),
        .reset (reset),
        .req   ({ldr_req && ldr_st == SEC_IDLE, vid_req && vid_st == SEC_IDLE}),
        .block (cpu_req),
        .gnt   (gnt)
    );

    // secondary port state: a grant parks the port for exactly the ack cycle
    always_ff @(posedge clk25)
        if (reset) begin
            vid_st <= SEC_IDLE;
            ldr_st <= SEC_IDLE;
        end else begin
            vid_st <= vid_nx;
            ldr_st <= ldr_nx;
        end

    // next secondary state and the owner of the data returning next cycle
    always_comb begin
        vid_nx   = (vid_st == SEC_WAIT) ? SEC_IDLE : (gnt[0] ? SEC_WAIT : SEC_IDLE);
        ldr_nx   = (ldr_st == SEC_WAIT) ? SEC_IDLE : (gnt[1] ? SEC_WAIT : SEC_IDLE);
        owner_nx = (cpu_req && !reset) ? (cpu_we ? OWN_NONE : OWN_CPU)
                 : gnt[0] ? OWN_VID : gnt[1] ? OWN_LDR : OWN_NONE;
    end

    // RAM port mux: CPU wins outright, idle cycles keep the previous address
    always_comb begin
        ram_addr = reset ? '0 : cpu_req ? cpu_addr : gnt[0] ? vid_addr : gnt[1] ? ldr_addr : last_addr;
        ram_din  = reset ? '0 : cpu_req ? cpu_din : gnt[1] ? ldr_din : last_din;
        ram_we   = !reset && (cpu_req ? cpu_we : gnt[1]);
    end

    // completions steered by the registered owner; reset squashes anything in flight
    always_comb begin
        cpu_valid = !reset && inflight_owner == OWN_CPU;
        vid_ack   = !reset && inflight_owner == OWN_VID;
        ldr_ack   = !reset && inflight_owner == OWN_LDR;
        cpu_dout  = reset ? {DATA_W{1'b1}} : cpu_valid ? ram_dout : cpu_hold;
        vid_dout  = reset ? '0 : vid_ack ? ram_dout : vid_hold;
    end

    // in-flight owner, held RAM drive and held read data
    always_ff @(posedge clk25)
        if (reset) begin
            inflight_owner <= OWN_NONE;
            last_addr      <= '0;
            last_din       <= '0;
            cpu_hold       <= {DATA_W{1'b1}};
            vid_hold       <= '0;
        end else begin
            inflight_owner <= owner_nx;
            last_addr      <= ram_addr;
            last_din       <= ram_din;
            cpu_hold       <= cpu_dout;
            vid_hold       <= vid_dout;
        end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized checks of ram_arbiter against a memory/latency model
module tb_ram_arbiter;
    logic        clk25 = 1'b0;
    logic        reset, cpu_req, cpu_we, vid_req, ldr_req;
    logic [12:0] cpu_addr, vid_addr, ldr_addr;
    logic [7:0]  cpu_din, ldr_din;
    logic [7:0]  cpu_dout, vid_dout, ram_din, ram_dout;
    logic        cpu_valid, vid_ack, ldr_ack, ram_we;
    logic [12:0] ram_addr;

    logic [7:0]  mem     [0:8191];
    logic [7:0]  ref_mem [0:8191];

    logic [7:0]  s_cpu_dout, s_vid_dout, s_ram_din;
    logic        s_cpu_valid, s_vid_ack, s_ldr_ack, s_ram_we;
    logic [12:0] s_ram_addr;
    logic        rd_flag, exp_valid;
    logic [7:0]  rd_exp, exp_dout;
    int          tests, fails, cyc_n, v_p, l_p, gap;

    ram_arbiter dut (
        .clk25(clk25), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_valid(cpu_valid),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_dout(vid_dout),
        .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_din(ldr_din), .ldr_ack(ldr_ack),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #20 clk25 = ~clk25;

    initial for (int i = 0; i < 8192; i++) mem[i] <= 8'(i * 7 + 3);

    always @(posedge clk25) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk25);
        s_cpu_dout  = cpu_dout;  s_cpu_valid = cpu_valid;
        s_vid_ack   = vid_ack;   s_vid_dout  = vid_dout;
        s_ldr_ack   = ldr_ack;   s_ram_addr  = ram_addr;
        s_ram_we    = ram_we;    s_ram_din   = ram_din;
        exp_valid = rd_flag && !reset;
        exp_dout  = rd_exp;
        if (!reset && s_ldr_ack) ref_mem[ldr_addr] = ldr_din;
        if (!reset && cpu_req && cpu_we) ref_mem[cpu_addr] = cpu_din;
        rd_flag = !reset && cpu_req && !cpu_we;
        rd_exp  = ref_mem[cpu_addr];
        cyc_n++;
        @(posedge clk25);
        #1;
    endtask

    initial begin
        tests = 0; fails = 0; cyc_n = 0; rd_flag = 0; rd_exp = 0;
        for (int i = 0; i < 8192; i++) ref_mem[i] = 8'(i * 7 + 3);
        reset = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_din = 0;
        vid_req = 0; vid_addr = 0; ldr_req = 0; ldr_addr = 0; ldr_din = 0;
        cyc(); cyc();
        chk("rst_ram_we", 32'(s_ram_we), 0);
        chk("rst_ram_addr", 32'(s_ram_addr), 0);
        chk("rst_cpu_dout", 32'(s_cpu_dout), 'hFF);
        chk("rst_cpu_valid", 32'(s_cpu_valid), 0);
        chk("rst_vid_dout", 32'(s_vid_dout), 0);
        chk("rst_vid_ack", 32'(s_vid_ack), 0);
        chk("rst_ldr_ack", 32'(s_ldr_ack), 0);
        reset = 0;

        // CPU write then read back
        cpu_req = 1; cpu_we = 1; cpu_addr = 13'h0123; cpu_din = 8'hA5; cyc();
        chk("t1_wr_we", 32'(s_ram_we), 1);
        chk("t1_wr_addr", 32'(s_ram_addr), 'h123);
        cpu_we = 0; cyc();
        chk("t1_rd_we", 32'(s_ram_we), 0);
        chk("t1_wr_no_valid", 32'(s_cpu_valid), 0);
        cpu_req = 0; cyc();
        chk("t1_valid", 32'(s_cpu_valid), 1);
        chk("t1_dout", 32'(s_cpu_dout), 'hA5);
        chk("t1_vid_ack", 32'(s_vid_ack), 0);
        chk("t1_ldr_ack", 32'(s_ldr_ack), 0);
        cyc();
        chk("t1_valid_pulse", 32'(s_cpu_valid), 0);
        chk("t1_dout_hold", 32'(s_cpu_dout), 'hA5);

        // loader write then video read of the same address
        ldr_req = 1; ldr_addr = 13'h0040; ldr_din = 8'h3C; cyc();
        chk("t2_ldr_we", 32'(s_ram_we), 1);
        chk("t2_ldr_addr", 32'(s_ram_addr), 'h40);
        chk("t2_ldr_din", 32'(s_ram_din), 'h3C);
        vid_req = 1; vid_addr = 13'h0040; cyc();
        chk("t2_ldr_ack", 32'(s_ldr_ack), 1);
        chk("t2_vid_issue", 32'(s_ram_addr), 'h40);
        chk("t2_vid_ack_early", 32'(s_vid_ack), 0);
        ldr_req = 0; cyc();
        chk("t2_vid_ack", 32'(s_vid_ack), 1);
        chk("t2_vid_dout", 32'(s_vid_dout), 'h3C);
        chk("t2_ldr_ack_pulse", 32'(s_ldr_ack), 0);
        vid_req = 0; cyc();
        chk("t2_vid_ack_pulse", 32'(s_vid_ack), 0);
        chk("t2_vid_hold", 32'(s_vid_dout), 'h3C);

        // both secondaries saturated: vid was served last, so ldr goes first
        vid_req = 1; vid_addr = 13'h0040; ldr_req = 1; ldr_addr = 13'h0041; ldr_din = 8'h77;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (i == 0) chk("t3_ldr_first", 32'(s_ram_we), 1);
            else begin
                chk("t3_ldr_ack", 32'(s_ldr_ack), 32'(i % 2 == 1));
                chk("t3_vid_ack", 32'(s_vid_ack), 32'(i % 2 == 0));
                if (s_vid_ack) chk("t3_vid_dout", 32'(s_vid_dout), 'h3C);
            end
        end
        vid_req = 0; ldr_req = 0; cyc();
        chk("t3_dropped_ack", 32'(s_vid_ack), 1);
        cyc();

        // CPU collides with video
        cpu_req = 1; cpu_we = 0; cpu_addr = 13'h0040; vid_req = 1; vid_addr = 13'h0123; cyc();
        chk("t4_cpu_first", 32'(s_ram_addr), 'h40);
        cpu_req = 0; cyc();
        chk("t4_valid", 32'(s_cpu_valid), 1);
        chk("t4_dout", 32'(s_cpu_dout), 'h3C);
        chk("t4_vid_ack_delayed", 32'(s_vid_ack), 0);
        chk("t4_vid_issue", 32'(s_ram_addr), 'h123);
        cyc();
        chk("t4_vid_ack", 32'(s_vid_ack), 1);
        chk("t4_vid_dout", 32'(s_vid_dout), 'hA5);
        vid_req = 0; cyc();

        // reset the cycle after a video grant
        vid_req = 1; vid_addr = 13'h0010; cyc();
        chk("t5_grant", 32'(s_ram_addr), 'h10);
        vid_req = 0; reset = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 13'h0050; cpu_din = 8'hEE; cyc();
        chk("t5_vid_ack", 32'(s_vid_ack), 0);
        chk("t5_ram_we", 32'(s_ram_we), 0);
        chk("t5_ram_addr", 32'(s_ram_addr), 0);
        chk("t5_ram_din", 32'(s_ram_din), 0);
        chk("t5_cpu_dout", 32'(s_cpu_dout), 'hFF);
        chk("t5_vid_dout", 32'(s_vid_dout), 0);
        chk("t5_cpu_valid", 32'(s_cpu_valid), 0);
        reset = 0; cpu_req = 0; cyc();
        chk("t5_post_vid_ack", 32'(s_vid_ack), 0);
        chk("t5_post_ram_addr", 32'(s_ram_addr), 0);
        chk("t5_post_cpu_dout", 32'(s_cpu_dout), 'hFF);
        chk("t5_post_vid_dout", 32'(s_vid_dout), 0);
        vid_req = 1; vid_addr = 13'h1000; ldr_req = 1; ldr_addr = 13'h0200; ldr_din = 8'h11; cyc();
        chk("t5_rr_vid_first", 32'(s_ram_addr), 'h1000);
        chk("t5_rr_vid_we", 32'(s_ram_we), 0);

        // randomized traffic: saturated secondaries plus sparse CPU accesses
        v_p = cyc_n; l_p = cyc_n; gap = 0;
        for (int n = 0; n < 3000; n++) begin
            cyc();
            chk("r_cpu_valid", 32'(s_cpu_valid), 32'(exp_valid));
            if (exp_valid) chk("r_cpu_dout", 32'(s_cpu_dout), 32'(exp_dout));
            if (s_vid_ack) begin
                chk("r_vid_latency_ok", 32'(cyc_n - v_p <= 3), 1);
                chk("r_vid_dout", 32'(s_vid_dout), 32'(ref_mem[vid_addr]));
                vid_addr = 13'h1000 + 13'($urandom_range(0, 255));
                v_p = cyc_n + 1;
            end else if (cyc_n - v_p == 6) chk("r_vid_ack_timeout", 32'(s_vid_ack), 1);
            if (s_ldr_ack) begin
                chk("r_ldr_latency_ok", 32'(cyc_n - l_p <= 3), 1);
                ldr_addr = 13'($urandom_range(0, 'hFFF));
                ldr_din  = 8'($urandom);
                l_p = cyc_n + 1;
            end else if (cyc_n - l_p == 6) chk("r_ldr_ack_timeout", 32'(s_ldr_ack), 1);
            cpu_req = 0;
            gap++;
            if (gap >= 26 && $urandom_range(0, 25) == 0) begin
                cpu_req = 1;
                cpu_we  = 1'($urandom);
                cpu_addr = cpu_we ? 13'($urandom_range(0, 'hFFF)) : 13'($urandom_range(0, 'h10FF));
                cpu_din = 8'($urandom);
                gap = 0;
            end
        end
        cpu_req = 0; vid_req = 0; ldr_req = 0;
        cyc(); cyc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
